// File: rtl/store_buffer.sv
// Store buffer: checks MEM-stage stores for AdES, builds byte lanes, queues them in a small FIFO
// and drains one entry at a time to the DM/timer bridge over a req/ack handshake.
module store_buffer #(
  parameter int unsigned DEPTH  = 2,
  parameter logic [31:0] DM_END = 32'h0000_2fff
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_st_valid,
  input  logic [1:0]  i_lsop,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wd_in,
  input  logic        i_flush,
  output logic        o_mem_exc_ades,
  output logic        o_st_stall,
  input  logic        i_ld_valid,
  input  logic [31:0] i_ld_addr,
  output logic        o_ld_conflict,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_byteen,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  output logic        o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [31:0]    r_addr [DEPTH];
  logic [3:0]     r_be   [DEPTH];
  logic [31:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [PW:0]    r_count;

  logic        w_req;
  logic        w_align;
  logic        w_in_dm;
  logic        w_in_tc0;
  logic        w_in_tc1;
  logic        w_in_stall;
  logic        w_in_cnt;
  logic        w_range;
  logic        w_timer;
  logic        w_full;
  logic        w_nonempty;
  logic        w_enq;
  logic        w_pop;
  logic        w_ld_hit;
  logic [3:0]  w_be;
  logic [31:0] w_data;

  assign w_req = i_st_valid && (i_lsop != 2'b00);

  always_comb begin
    w_align    = ((i_lsop == 2'b11) && (i_addr[1:0] != 2'b00)) ||
                 ((i_lsop == 2'b10) && i_addr[0]);
    w_in_dm    = (i_addr <= DM_END);
    w_in_tc0   = (i_addr >= 32'h0000_7f00) && (i_addr <= 32'h0000_7f0b);
    w_in_tc1   = (i_addr >= 32'h0000_7f10) && (i_addr <= 32'h0000_7f1b);
    w_in_stall = (i_addr >= 32'h0000_7f20) && (i_addr <= 32'h0000_7f23);
    // Timer count registers are read-only from the store side.
    w_in_cnt   = ((i_addr >= 32'h0000_7f08) && (i_addr <= 32'h0000_7f0b)) ||
                 ((i_addr >= 32'h0000_7f18) && (i_addr <= 32'h0000_7f1b));
    w_range    = !(w_in_dm || w_in_tc0 || w_in_tc1 || w_in_stall);
    w_timer    = (w_in_tc0 || w_in_tc1) && ((i_lsop != 2'b11) || w_in_cnt);
  end

  assign o_mem_exc_ades = w_req && (w_align || w_range || w_timer);

  always_comb begin
    w_be   = 4'b0000;
    w_data = 32'h0;
    unique case (i_lsop)
      2'b01: begin
        w_be   = 4'b0001 << i_addr[1:0];
        w_data = {4{i_wd_in[7:0]}};
      end
      2'b10: begin
        w_be   = i_addr[1] ? 4'b1100 : 4'b0011;
        w_data = {2{i_wd_in[15:0]}};
      end
      2'b11: begin
        w_be   = 4'b1111;
        w_data = i_wd_in;
      end
      default: begin
        w_be   = 4'b0000;
        w_data = 32'h0;
      end
    endcase
  end

  assign w_full     = (r_count == FULL_CNT);
  assign w_nonempty = (r_count != '0);
  assign w_enq      = w_req && !o_mem_exc_ades && !i_flush && !w_full;
  assign w_pop      = w_nonempty && i_bus_ack;
  assign o_st_stall = w_req && !o_mem_exc_ades && !i_flush && w_full;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= 32'h0;
        r_be[i]   <= 4'b0000;
        r_data[i] <= 32'h0;
      end
    end else begin
      if (w_enq) begin
        r_addr[r_wr_ptr]  <= {i_addr[31:2], 2'b00};
        r_be[r_wr_ptr]    <= w_be;
        r_data[r_wr_ptr]  <= w_data;
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      unique case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entries being popped still hold valid; the one being written does not yet.
  always_comb begin
    w_ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i][31:2] == i_ld_addr[31:2])) w_ld_hit = 1'b1;
    end
  end

  assign o_ld_conflict = i_ld_valid && w_ld_hit;
  assign o_bus_req     = w_nonempty;
  assign o_bus_addr    = w_nonempty ? r_addr[r_rd_ptr] : 32'h0;
  assign o_bus_byteen  = w_nonempty ? r_be[r_rd_ptr] : 4'b0000;
  assign o_bus_wdata   = w_nonempty ? r_data[r_rd_ptr] : 32'h0;
  assign o_empty       = !w_nonempty;

endmodule
